sobel_frame_ctrl: RTL

- Sequences the pixel stream into the Sobel datapath and drives the shared frame counter (inc/sync_clr), reading back its position.
- Handles start/abort, start-of-frame (SOF) alignment, multi-frame runs, 3x3 window-valid generation and a pipeline drain after each frame.
- Sits between the pixel source and the Sobel core; the frame counter is instantiated beside it at top level.

---
 rtl/sobel_pkg.sv | 23 ++
 rtl/sobel_frame_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
// Shared definitions for the Sobel frame controller and its neighbours:
//   - ctrl_state_t : controller state encoding
//   - HMAX_DEF     : default pixels per line
//   - VMAX_DEF     : default lines per frame
//   - POS_W        : width of the frame counter hcount/vcount positions
// -----------------------------------------------------------------------------
package sobel_pkg;

    localparam int HMAX_DEF = 640;
    localparam int VMAX_DEF = 480;
    localparam int POS_W    = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_ACTIVE,
        ST_DRAIN,
        ST_DONE
    } ctrl_state_t;

endpackage

// File: rtl/sobel_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sobel_frame_ctrl
// Sequences a pixel stream into the Sobel datapath. Drives the shared frame
// counter (cnt_inc / cnt_clr) and reads its position back (hcount, vcount,
// frame_end). Handles start/abort, SOF alignment, multi-frame runs, 3x3
// window-valid generation and a pipeline drain after every frame.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start, abort        run request (IDLE only) / return to IDLE from anywhere
//   cfg_frames          frames per run, 0 = continuous (sampled on start)
//   pix_valid, pix_sof  source pixel handshake and SOF marker
//   pix_ready           controller accepts a pixel this cycle
//   out_ready           downstream Sobel core can take a pixel
//   hcount, vcount      frame counter position (pre-increment)
//   frame_end           frame counter at last pixel of the frame
//   cnt_inc, cnt_clr    frame counter controls (never both high)
//   win_valid           accepted pixel completes an interior 3x3 window
//   busy                controller not idle
//   frame_done          pulse when a frame's drain completes
//   run_done            pulse when the run finishes
//   frames_done         frames completed in the current run
//   sof_err             sticky: SOF seen mid-frame
//   drop_cnt            discarded pixel count
//
// Build option: SOBEL_FRAME_CTRL_STATS_EN enables the saturating drop_cnt
// counter; without it drop_cnt is tied to zero.
// -----------------------------------------------------------------------------
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int HMAX     = HMAX_DEF,
    parameter int VMAX     = VMAX_DEF,
    parameter int PIPE_LAT = 4,
    parameter int FCNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [FCNT_W-1:0] cfg_frames,
    input  logic              pix_valid,
    input  logic              pix_sof,
    output logic              pix_ready,
    input  logic              out_ready,
    input  logic [POS_W-1:0]  hcount,
    input  logic [POS_W-1:0]  vcount,
    input  logic              frame_end,
    output logic              cnt_inc,
    output logic              cnt_clr,
    output logic              win_valid,
    output logic              busy,
    output logic              frame_done,
    output logic              run_done,
    output logic [FCNT_W-1:0] frames_done,
    output logic              sof_err,
    output logic [15:0]       drop_cnt
);

    localparam int DW = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

    ctrl_state_t       r_state;
    ctrl_state_t       w_next;

    logic [FCNT_W-1:0] r_cfg_frames;
    logic [FCNT_W-1:0] r_frames_done;
    logic [FCNT_W-1:0] w_frames_next;
    logic              r_sof_err;
    logic [DW-1:0]     r_drain;

    logic              w_accept;
    logic              w_at_origin;
    logic              w_drain_last;
    logic              w_start_run;
    logic              w_sof_err_set;
    logic              w_wait_drop;
    logic              w_drain_load;
    logic              w_drain_dec;
    logic              w_frame_cnt;

    assign pix_ready     = out_ready & ((r_state == ST_WAIT_SOF) | (r_state == ST_ACTIVE));
    assign w_accept      = pix_valid & pix_ready;
    assign w_at_origin   = (hcount == '0) & (vcount == '0);
    assign w_frames_next = r_frames_done + FCNT_W'(1);
    // PIPE_LAT of 0 still needs one DRAIN cycle to report completion.
    assign w_drain_last  = (r_drain <= DW'(1));
    assign busy          = (r_state != ST_IDLE);
    assign frames_done   = r_frames_done;
    assign sof_err       = r_sof_err;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        cnt_inc       = 1'b0;
        cnt_clr       = 1'b0;
        win_valid     = 1'b0;
        frame_done    = 1'b0;
        run_done      = 1'b0;
        w_start_run   = 1'b0;
        w_sof_err_set = 1'b0;
        w_wait_drop   = 1'b0;
        w_drain_load  = 1'b0;
        w_drain_dec   = 1'b0;
        w_frame_cnt   = 1'b0;

        if (abort) begin
            w_next  = ST_IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_next      = ST_WAIT_SOF;
                        cnt_clr     = 1'b1;
                        w_start_run = 1'b1;
                    end
                end
                ST_WAIT_SOF: begin
                    if (w_accept) begin
                        if (pix_sof) begin
                            cnt_inc = 1'b1;
                            w_next  = ST_ACTIVE;
                        end else begin
                            w_wait_drop = 1'b1;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (w_accept) begin
                        if (pix_sof & ~w_at_origin) begin
                            // Realign: drop this pixel and restart the frame.
                            cnt_clr       = 1'b1;
                            w_sof_err_set = 1'b1;
                            w_next        = ST_WAIT_SOF;
                        end else begin
                            cnt_inc   = 1'b1;
                            win_valid = (hcount >= POS_W'(2)) & (vcount >= POS_W'(2));
                            if (frame_end) begin
                                w_next       = ST_DRAIN;
                                w_drain_load = 1'b1;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (w_drain_last) begin
                            frame_done  = 1'b1;
                            w_frame_cnt = 1'b1;
                            if ((r_cfg_frames != '0) && (w_frames_next == r_cfg_frames)) begin
                                w_next = ST_DONE;
                            end else begin
                                w_next = ST_WAIT_SOF;
                            end
                        end else begin
                            w_drain_dec = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    run_done = 1'b1;
                    w_next   = ST_IDLE;
                end
                default: begin
                    w_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cfg_frames  <= '0;
            r_frames_done <= '0;
            r_sof_err     <= 1'b0;
            r_drain       <= '0;
        end else begin
            if (w_start_run) begin
                r_cfg_frames  <= cfg_frames;
                r_frames_done <= '0;
                r_sof_err     <= 1'b0;
            end
            if (w_sof_err_set) begin
                r_sof_err <= 1'b1;
            end
            if (w_frame_cnt) begin
                r_frames_done <= w_frames_next;
            end
            if (w_drain_load) begin
                r_drain <= DW'(PIPE_LAT);
            end else if (w_drain_dec) begin
                r_drain <= r_drain - DW'(1);
            end
        end
    end

`ifdef SOBEL_FRAME_CTRL_STATS_EN
    logic [15:0] r_drop_cnt;
    logic        w_drop_evt;

    assign w_drop_evt = w_wait_drop | w_sof_err_set;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_drop_cnt <= '0;
        end else if (w_start_run) begin
            r_drop_cnt <= '0;
        end else if (w_drop_evt && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`else
    logic w_unused_drop;
    assign w_unused_drop = w_wait_drop;
    assign drop_cnt      = '0;
`endif

    // The counter's frame_end must agree with the configured geometry.
    assert property (@(posedge clk) disable iff (!reset_n)
        frame_end |-> ((hcount == POS_W'(HMAX - 1)) && (vcount == POS_W'(VMAX - 1))));

endmodule
